// File: rtl/pipes.sv
// Shared pipeline types for the fetch/decode boundary.
package pipes;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef struct packed {
        u32   raw_instr;
        u64   pc;
        logic is_bubble;
    } fetch_data_t;

    // Depth used by every fetch_queue instantiation in the pipeline.
    localparam int FETCH_QUEUE_DEPTH = 4;

    // What decode sees when nothing is queued.
    localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: 32'h0, pc: 64'h0, is_bubble: 1'b1};

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: DEPTH-entry FIFO between the imem response path
// and decode. Presents a bubble when empty, so decode needs no stall logic.
// in_ready/out_valid/count come from registers only; when full, a same-cycle
// pop does not admit a push (no ready path from out_ready).
module fetch_queue
    import pipes::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  u32                           in_raw_instr,
    input  u64                           in_pc,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         out_valid,
    output fetch_data_t                  dataF,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_data_t        mem_q [DEPTH];
    fetch_data_t        mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push;
    logic               pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Head of queue, or a bubble when empty.
    always_comb begin
        dataF = FETCH_BUBBLE;
        if (out_valid) begin
            dataF           = mem_q[rd_ptr_q];
            dataF.is_bubble = 1'b0;
        end
    end

    // Next-state for pointers, occupancy and storage; flush discards everything.
    always_comb begin
        push     = in_valid && in_ready && !flush;
        pop      = out_valid && out_ready && !flush;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{raw_instr: in_raw_instr, pc: in_pc, is_bubble: 1'b0};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through a valid head, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner-case
// sequences, DEPTH=2/8 thresholds and a randomized run against a queue model.
module tb_fetch_queue;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv, ordy, fl;
    u64          pc;
    u32          raw;
    logic        in_ready, out_valid;
    fetch_data_t dataF;
    logic [2:0]  count;

    logic        xv, xr;
    logic        ir2, ov2, ir8, ov8;
    fetch_data_t df2, df8;
    logic [1:0]  count2;
    logic [3:0]  count8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(FETCH_QUEUE_DEPTH)) u_dut (
        .clk(clk), .reset(reset), .in_valid(iv), .in_raw_instr(raw), .in_pc(pc),
        .in_ready(in_ready), .out_ready(ordy), .out_valid(out_valid),
        .dataF(dataF), .flush(fl), .count(count)
    );

    fetch_queue #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(xv), .in_raw_instr(raw), .in_pc(pc),
        .in_ready(ir2), .out_ready(xr), .out_valid(ov2),
        .dataF(df2), .flush(1'b0), .count(count2)
    );

    fetch_queue #(.DEPTH(8)) u_d8 (
        .clk(clk), .reset(reset), .in_valid(xv), .in_raw_instr(raw), .in_pc(pc),
        .in_ready(ir8), .out_ready(xr), .out_valid(ov8),
        .dataF(df8), .flush(1'b0), .count(count8)
    );

    function automatic u32 raw_of(u64 p);
        return p[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Full observation of the DEPTH=4 instance against expected values.
    task automatic chk_out(string nm, int ecnt, bit eov, bit eir, u64 epc);
        chk({nm, ".count"}, 64'(count), 64'(ecnt));
        chk({nm, ".out_valid"}, 64'(out_valid), 64'(eov));
        chk({nm, ".in_ready"}, 64'(in_ready), 64'(eir));
        chk({nm, ".pc"}, dataF.pc, eov ? epc : 64'h0);
        chk({nm, ".raw"}, 64'(dataF.raw_instr), eov ? 64'(raw_of(epc)) : 64'h0);
        chk({nm, ".bubble"}, 64'(dataF.is_bubble), 64'(!eov));
    endtask

    task automatic drive(bit v, bit r, bit f, u64 p);
        iv = v; ordy = r; fl = f; pc = p; raw = raw_of(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit iv, ordy, fl;
        u64 pc;
        int cnt;
        bit ov, ir;
        u64 hpc;
    } vec_t;

    vec_t vecs[13];
    u64   mq[$];

    initial begin
        vecs[0]  = '{1, 0, 0, 64'h8000_0000, 1, 1, 1, 64'h8000_0000};
        vecs[1]  = '{1, 0, 0, 64'h8000_0004, 2, 1, 1, 64'h8000_0000};
        vecs[2]  = '{1, 0, 0, 64'h8000_0008, 3, 1, 1, 64'h8000_0000};
        vecs[3]  = '{1, 0, 0, 64'h8000_000C, 4, 1, 0, 64'h8000_0000};
        vecs[4]  = '{1, 0, 0, 64'h8000_0010, 4, 1, 0, 64'h8000_0000};
        vecs[5]  = '{0, 1, 0, 64'h0,         3, 1, 1, 64'h8000_0004};
        vecs[6]  = '{0, 1, 0, 64'h0,         2, 1, 1, 64'h8000_0008};
        vecs[7]  = '{0, 1, 0, 64'h0,         1, 1, 1, 64'h8000_000C};
        vecs[8]  = '{0, 1, 0, 64'h0,         0, 0, 1, 64'h0};
        vecs[9]  = '{0, 1, 0, 64'h0,         0, 0, 1, 64'h0};
        vecs[10] = '{1, 1, 0, 64'h100,       1, 1, 1, 64'h100};
        vecs[11] = '{1, 1, 1, 64'h104,       0, 0, 1, 64'h0};
        vecs[12] = '{0, 1, 0, 64'h0,         0, 0, 1, 64'h0};

        reset = 1'b0; xv = 1'b0; xr = 1'b0;
        drive(0, 0, 0, 64'h0);
        step();
        step();
        chk_out("in_reset", 0, 0, 1, 64'h0);
        reset = 1'b1;
        step();
        chk_out("idle", 0, 0, 1, 64'h0);

        // DEPTH=2 and DEPTH=8 fill/drain thresholds
        for (int k = 1; k <= 10; k++) begin
            xv = 1'b1; xr = 1'b0; pc = 64'h1000 + 64'(4 * k); raw = raw_of(pc);
            step();
            chk("d2.fill_count", 64'(count2), 64'((k < 2) ? k : 2));
            chk("d8.fill_count", 64'(count8), 64'((k < 8) ? k : 8));
            chk("d2.fill_ready", 64'(ir2), 64'(k < 2));
            chk("d8.fill_ready", 64'(ir8), 64'(k < 8));
        end
        for (int k = 1; k <= 10; k++) begin
            xv = 1'b0; xr = 1'b1;
            chk("d8.drain_pc", df8.pc, (k <= 8) ? 64'h1000 + 64'(4 * k) : 64'h0);
            step();
            chk("d2.drain_count", 64'(count2), 64'((k < 2) ? 2 - k : 0));
            chk("d8.drain_count", 64'(count8), 64'((k < 8) ? 8 - k : 0));
            chk("d2.drain_valid", 64'(ov2), 64'(k < 2));
            chk("d8.drain_valid", 64'(ov8), 64'(k < 8));
        end
        chk("d2.bubble", 64'(df2.is_bubble), 64'h1);
        xr = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir, vecs[i].hpc);
        end

        // Streaming at count=1 across pointer wrap
        drive(1, 0, 0, 64'h2000);
        step();
        chk_out("stream_prime", 1, 1, 1, 64'h2000);
        for (int k = 1; k <= 20; k++) begin
            drive(1, 1, 0, 64'h2000 + 64'(4 * k));
            step();
            chk_out($sformatf("stream%0d", k), 1, 1, 1, 64'h2000 + 64'(4 * k));
        end
        drive(0, 1, 0, 64'h0);
        step();
        chk_out("stream_drain", 0, 0, 1, 64'h0);

        // Flush with push and pop in the same cycle at count=3
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 64'h3000 + 64'(4 * k));
            step();
        end
        chk_out("pre_flush", 3, 1, 1, 64'h3000);
        drive(1, 1, 1, 64'hDEAD0);
        step();
        chk_out("flush", 0, 0, 1, 64'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 64'h0);
            step();
            chk_out("post_flush", 0, 0, 1, 64'h0);
        end
        drive(1, 0, 0, 64'h300);
        step();
        chk_out("after_flush_push", 1, 1, 1, 64'h300);
        drive(0, 1, 0, 64'h0);
        step();
        chk_out("after_flush_pop", 0, 0, 1, 64'h0);

        // Reset mid-stream at count=2
        drive(1, 0, 0, 64'h400);
        step();
        drive(1, 0, 0, 64'h404);
        step();
        chk_out("pre_reset", 2, 1, 1, 64'h400);
        drive(1, 1, 0, 64'h408);
        reset = 1'b0;
        step();
        chk_out("mid_reset", 0, 0, 1, 64'h0);
        reset = 1'b1;
        drive(1, 0, 0, 64'h200);
        step();
        chk_out("post_reset_push", 1, 1, 1, 64'h200);
        drive(0, 1, 0, 64'h0);
        step();
        chk_out("post_reset_pop", 0, 0, 1, 64'h0);

        // Randomized run against a queue model
        mq.delete();
        for (int k = 0; k < 600; k++) begin
            bit v, r, f, rs;
            int sz;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            f  = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 63) == 0);
            drive(v, r, f, 64'h8000_0000 + 64'(4 * k));
            reset = !rs;
            sz = mq.size();
            if (rs || f) begin
                mq.delete();
            end else begin
                if (r && sz != 0) void'(mq.pop_front());
                if (v && sz < FETCH_QUEUE_DEPTH) mq.push_back(pc);
            end
            step();
            chk_out($sformatf("rand%0d", k), mq.size(), mq.size() != 0,
                    mq.size() != FETCH_QUEUE_DEPTH, (mq.size() != 0) ? mq[0] : 64'h0);
        end
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch buffer between the instruction-memory response path and decode. It replaces the single-entry continue/maintain hold register with a DEPTH-entry FIFO of `fetch_data_t` and adds valid/ready handshakes on both sides, a flush for redirects, and an occupancy count. When empty it presents a bubble to decode, so the downstream stages need no separate stall logic.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; state clears on a rising `clk` edge while `reset`==0.
- `in_valid`  in  1: the fetch response is valid this cycle.
- `in_raw_instr`  in  32 (`u32`): fetched instruction.
- `in_pc`  in  64 (`u64`): PC of the fetched instruction.
- `in_ready`  out  1: the queue can accept an entry this cycle.
- `out_ready`  in  1: decode consumes the head this cycle.
- `out_valid`  out  1: the head entry is valid.
- `dataF`  out  `fetch_data_t`: head entry `{raw_instr, pc, is_bubble}`.
- `flush`  in  1: redirect; discard all contents.
- `count`  out  $clog2(DEPTH+1): current occupancy.

## Operation
- Storage: DEPTH-entry register array, head pointer `rd_ptr`, tail pointer `wr_ptr`, occupancy counter `count`.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push occurs when `in_valid && in_ready && !flush`.
  - Writes `{in_raw_instr, in_pc, is_bubble=0}` at `wr_ptr`, then increments `wr_ptr`.
- Pop occurs when `out_valid && out_ready && !flush`.
  - Increments `rd_ptr`.
- `count` next-state:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Flush has priority over push and pop in the same cycle.
  - Next state: `rd_ptr`=`wr_ptr`=0, `count`=0.
  - A response arriving in the flush cycle is dropped.
  - A pop in the flush cycle does not count as consumed.
- `in_ready` = (`count` != DEPTH).
  - It is derived from registered state only, with no combinational path from `out_ready`.
  - When the queue is full, a same-cycle pop does not admit a push. This is accepted throughput loss.
- `out_valid` = (`count` != 0).
- `dataF` when `out_valid`=1: the entry at `rd_ptr`, with `is_bubble`=0.
- `dataF` when `out_valid`=0: `raw_instr`=0, `pc`=0, `is_bubble`=1.
  - Never X; `dataF` is fully assigned in all cases.
- Pop while empty: ignored; no pointer change, and `count` never underflows.
- Push while full: impossible by construction because `in_ready`=0. Any `in_valid` while full is ignored.

## Timing
- Reset values:
  - `count`=0, `in_ready`=1, `out_valid`=0.
  - `dataF` = bubble {0, 0, 1}.
  - Both pointers 0.
- Reset applied mid-operation has the same effect as flush and wins over flush, push and pop.
- Latency: an entry pushed at edge N is visible on `dataF` with `out_valid`=1 in the cycle after edge N.
  - There is no same-cycle bypass from input to output.
- Sustained throughput is one push and one pop per cycle whenever 0 < `count` < DEPTH.
- After flush at edge N, in the following cycle: `out_valid`=0, `in_ready`=1, `count`=0.
- `in_ready`, `out_valid` and `count` are functions of registers only.
- `dataF` is a mux of registers by `rd_ptr`.

## Structure
- `fetch_data_t` stays in the `pipes` package unchanged.
- Add a default-depth constant `FETCH_QUEUE_DEPTH` (=4) to `pipes`. Instantiations use it.
- No sub-module: storage is a plain register array inside `fetch_queue`.
- Occupancy width is computed locally from `DEPTH`.

## Test plan
- Reset, then idle: `count`=0, `in_ready`=1, `out_valid`=0, `dataF`={0, 0, 1}.
- DEPTH=4, `out_ready`=0, push pc 0x80000000/04/08/0C:
  - After the 4th edge: `count`=4, `in_ready`=0.
  - A 5th `in_valid` with pc 0x10 is ignored.
  - Then `out_ready`=1 pops in order 0x00, 0x04, 0x08, 0x0C, followed by a bubble.
- Streaming with `in_valid`=`out_ready`=1 for 20 cycles starting from `count`=1:
  - `count` stays 1.
  - Output PCs are strictly in order across pointer wrap-around.
- `count`=3 with flush, `in_valid` and `out_ready` all asserted in one cycle:
  - Next cycle `count`=0 and `dataF` is a bubble.
  - The flush-cycle response never appears on `dataF`.
- `reset` driven low mid-stream with `count`=2:
  - Next cycle shows reset values.
  - After `reset` returns high, a push of pc 0x200 pops as the first output.
- DEPTH=2 and DEPTH=8 builds:
  - Full and empty thresholds are at 2 and 8 respectively.
  - `count` width is 2 and 4 bits respectively.
